// File: rtl/alu_pkg.sv
// alu_pkg: shared opcodes, FSM state type and flag bit positions for alu_pipe
package alu_pkg;
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SL  = 4'd6;
  localparam logic [3:0] OP_SR  = 4'd7;
  localparam logic [3:0] OP_CMP = 4'd8;
  localparam logic [3:0] OP_MUL = 4'd9;
  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_CARRY = 1;
  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;
endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: iterative shift-add multiplier, WIDTH busy cycles from start to done
module alu_mul_iter #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH);
  logic busy;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] mcand, acc;
  logic [WIDTH-1:0] mplier;
  always_comb product = acc + (mplier[0] ? mcand : '0);
  always_comb done = busy && cnt == CW'(WIDTH - 1);
  always_ff @(posedge clk)
    if (rst) begin
      busy <= 1'b0;
      cnt <= '0;
      mcand <= '0;
      acc <= '0;
      mplier <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt <= '0;
      mcand <= {{WIDTH{1'b0}}, a};
      acc <= '0;
      mplier <= b;
    end else if (busy) begin
      busy <= !done;
      cnt <= cnt + 1'b1;
      mcand <= mcand << 1;
      acc <= product;
      mplier <= mplier >> 1;
    end
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked ALU with registered result/flags; iterative MUL only when ALU_PIPE_MUL_EN is defined
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW = $clog2(WIDTH)
) (
  input  logic             iClock,
  input  logic             iReset,
  input  logic             iValid,
  output logic             oReady,
  input  logic [3:0]       iOperation,
  input  logic [WIDTH-1:0] iOperandA,
  input  logic [WIDTH-1:0] iOperandB,
  output logic             oValid,
  input  logic             iReady,
  output logic [WIDTH-1:0] oAluResult,
  output logic             oZero,
  output logic             oCarry
);
  state_t state, next;
  logic accept, is_mul, mul_done, mul_carry, sh_big;
  logic [WIDTH-1:0] shl, shr, mul_res;
  logic [WIDTH:0] alu;
  logic [1:0] flags;
  always_comb oReady = state == IDLE || (state == HOLD && iReady);
  always_comb oValid = state == HOLD;
  always_comb accept = iValid && oReady;
  always_comb oZero = flags[FLAG_ZERO];
  always_comb oCarry = flags[FLAG_CARRY];
  always_comb sh_big = iOperandB >= WIDTH'(WIDTH);
  always_comb shl = sh_big ? '0 : iOperandA << iOperandB[SHW-1:0];
  always_comb shr = sh_big ? '0 : iOperandA >> iOperandB[SHW-1:0];
  always_comb
    alu = iOperation == OP_ADD ? {1'b0, iOperandA} + {1'b0, iOperandB}
        : iOperation == OP_SUB ? {1'b0, iOperandA} - {1'b0, iOperandB}
        : iOperation == OP_AND ? {1'b0, iOperandA & iOperandB}
        : iOperation == OP_OR  ? {1'b0, iOperandA | iOperandB}
        : iOperation == OP_XOR ? {1'b0, iOperandA ^ iOperandB}
        : iOperation == OP_NOT ? {1'b0, ~iOperandA}
        : iOperation == OP_SL  ? {1'b0, shl}
        : iOperation == OP_SR  ? {1'b0, shr}
        : iOperation == OP_CMP ? {{WIDTH{1'b0}}, iOperandA == iOperandB}
        : '0;
`ifdef ALU_PIPE_MUL_EN
  logic [2*WIDTH-1:0] product;
  always_comb is_mul = iOperation == OP_MUL;
  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk(iClock),
    .rst(iReset),
    .start(accept && is_mul),
    .a(iOperandA),
    .b(iOperandB),
    .done(mul_done),
    .product(product)
  );
  always_comb mul_res = product[WIDTH-1:0];
  always_comb mul_carry = |product[2*WIDTH-1:WIDTH];
`else
  always_comb is_mul = 1'b0;
  always_comb mul_done = 1'b0;
  always_comb mul_res = '0;
  always_comb mul_carry = 1'b0;
`endif
  always_comb
    next = state == BUSY ? (mul_done ? HOLD : BUSY)
         : accept ? (is_mul ? BUSY : HOLD)
         : (state == HOLD && iReady) ? IDLE
         : state;
  always_ff @(posedge iClock)
    if (iReset) begin
      state <= IDLE;
      oAluResult <= '0;
      flags <= '0;
    end else begin
      state <= next;
      if (accept && !is_mul) begin
        oAluResult <= alu[WIDTH-1:0];
        flags[FLAG_ZERO] <= alu[WIDTH-1:0] == '0;
        flags[FLAG_CARRY] <= alu[WIDTH];
      end else if (mul_done) begin
        oAluResult <= mul_res;
        flags[FLAG_ZERO] <= mul_res == '0;
        flags[FLAG_CARRY] <= mul_carry;
      end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: table-driven single-cycle vectors plus handshake, reset and MUL sequences
module tb_alu_pipe;
  import alu_pkg::*;
  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        z;
    logic        c;
  } vec_t;
  logic clk = 1'b0;
  logic rst, in_valid, out_ready, out_valid, in_ready, zero, carry;
  logic [3:0] op;
  logic [15:0] a, b, res;
  int n_chk = 0;
  int n_err = 0;
  vec_t vt[$];
  alu_pipe #(.WIDTH(16)) dut (
    .iClock(clk),
    .iReset(rst),
    .iValid(in_valid),
    .oReady(out_ready),
    .iOperation(op),
    .iOperandA(a),
    .iOperandB(b),
    .oValid(out_valid),
    .iReady(in_ready),
    .oAluResult(res),
    .oZero(zero),
    .oCarry(carry)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic drive(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y);
    in_valid = 1'b1;
    op = o;
    a = x;
    b = y;
  endtask
  task automatic chk_out(input string nm, input logic v, input logic [15:0] r, input logic z, input logic c);
    chk({nm, "_valid"}, 32'(out_valid), 32'(v));
    chk({nm, "_res"}, 32'(res), 32'(r));
    chk({nm, "_zero"}, 32'(zero), 32'(z));
    chk({nm, "_carry"}, 32'(carry), 32'(c));
  endtask
  initial begin
    vt.push_back('{"add_wrap", OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1});
    vt.push_back('{"add", OP_ADD, 16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0});
    vt.push_back('{"sub_borrow", OP_SUB, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b1});
    vt.push_back('{"sub", OP_SUB, 16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0});
    vt.push_back('{"and", OP_AND, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0});
    vt.push_back('{"or", OP_OR, 16'hF000, 16'h000F, 16'hF00F, 1'b0, 1'b0});
    vt.push_back('{"xor_zero", OP_XOR, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 1'b0});
    vt.push_back('{"sl_big", OP_SL, 16'h0001, 16'h0010, 16'h0000, 1'b1, 1'b0});
    vt.push_back('{"sl_15", OP_SL, 16'h0001, 16'h000F, 16'h8000, 1'b0, 1'b0});
    vt.push_back('{"sr_4", OP_SR, 16'h8000, 16'h0004, 16'h0800, 1'b0, 1'b0});
    vt.push_back('{"sr_huge", OP_SR, 16'h8000, 16'hFFFF, 16'h0000, 1'b1, 1'b0});
    vt.push_back('{"cmp_eq", OP_CMP, 16'h1234, 16'h1234, 16'h0001, 1'b0, 1'b0});
    vt.push_back('{"cmp_ne", OP_CMP, 16'h1234, 16'h1235, 16'h0000, 1'b1, 1'b0});
    vt.push_back('{"undef_op", 4'hF, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 1'b0});
`ifndef ALU_PIPE_MUL_EN
    vt.push_back('{"mul_off", OP_MUL, 16'h0003, 16'h0007, 16'h0000, 1'b1, 1'b0});
`endif
    vt.push_back('{"not", OP_NOT, 16'h00FF, 16'h0000, 16'hFF00, 1'b0, 1'b0});
    rst = 1'b1;
    in_valid = 1'b0;
    in_ready = 1'b1;
    op = OP_ADD;
    a = '0;
    b = '0;
    tick();
    tick();
    chk_out("reset", 1'b0, 16'h0000, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    chk("reset_ready", 32'(out_ready), 32'd1);
    foreach (vt[i]) begin
      drive(vt[i].op, vt[i].a, vt[i].b);
      #1;
      chk({vt[i].name, "_ready"}, 32'(out_ready), 32'd1);
      tick();
      chk_out(vt[i].name, 1'b1, vt[i].res, vt[i].z, vt[i].c);
    end
    in_valid = 1'b0;
    tick();
    chk_out("drain", 1'b0, 16'hFF00, 1'b0, 1'b0);
    chk("drain_ready", 32'(out_ready), 32'd1);
    in_ready = 1'b0;
    drive(OP_CMP, 16'h1234, 16'h1234);
    tick();
    drive(OP_ADD, 16'h0001, 16'h0001);
    for (int k = 0; k < 3; k++) begin
      chk_out("bp_hold", 1'b1, 16'h0001, 1'b0, 1'b0);
      chk("bp_ready", 32'(out_ready), 32'd0);
      tick();
    end
    in_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(out_ready), 32'd1);
    tick();
    chk_out("bp_next", 1'b1, 16'h0002, 1'b0, 1'b0);
    in_valid = 1'b0;
    in_ready = 1'b0;
    tick();
    chk_out("hold_again", 1'b1, 16'h0002, 1'b0, 1'b0);
    rst = 1'b1;
    in_ready = 1'b1;
    drive(OP_ADD, 16'hFFFF, 16'hFFFF);
    tick();
    chk_out("rst_hold", 1'b0, 16'h0000, 1'b0, 1'b0);
    rst = 1'b0;
    drive(OP_ADD, 16'h0002, 16'h0003);
    #1;
    chk("post_rst_ready", 32'(out_ready), 32'd1);
    tick();
    chk_out("post_rst_add", 1'b1, 16'h0005, 1'b0, 1'b0);
    in_valid = 1'b0;
    tick();
`ifdef ALU_PIPE_MUL_EN
    drive(OP_MUL, 16'h0100, 16'h0100);
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk("mul_busy_ready", 32'(out_ready), 32'd0);
      chk("mul_busy_valid", 32'(out_valid), 32'd0);
      tick();
    end
    chk_out("mul_ovf", 1'b1, 16'h0000, 1'b1, 1'b1);
    drive(OP_MUL, 16'h0003, 16'h0007);
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 16; k++) tick();
    chk_out("mul_3x7", 1'b1, 16'h0015, 1'b0, 1'b0);
    drive(OP_MUL, 16'h0100, 16'h0100);
    tick();
    for (int k = 0; k < 4; k++) tick();
    rst = 1'b1;
    tick();
    chk_out("mul_rst", 1'b0, 16'h0000, 1'b0, 1'b0);
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("mul_rst_ready", 32'(out_ready), 32'd1);
    begin
      int seen = 0;
      for (int k = 0; k < 24; k++) begin
        if (out_valid) seen++;
        tick();
      end
      chk("mul_rst_no_stale", 32'(seen), 32'd0);
    end
`endif
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning operand/result width (legal 8..64).
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), meaning the width of the shift-amount field.
REQ-003 SHALL have port iClock, input, 1, meaning the single clock; all logic on posedge.
REQ-004 SHALL have port iReset, input, 1, meaning the reset: synchronous, active-high.
REQ-005 SHALL have port iValid, input, 1, meaning a request is present.
REQ-006 SHALL have port oReady, output, 1, meaning a request is accepted this cycle.
REQ-007 SHALL have port iOperation, input, 4, meaning the encoded opcode (package constants).
REQ-008 SHALL have ports iOperandA and iOperandB, input, WIDTH, meaning the operands.
REQ-009 SHALL have port oValid, output, 1, meaning oAluResult and the flags are valid.
REQ-010 SHALL have port iReady, input, 1, meaning the consumer takes the result.
REQ-011 SHALL have port oAluResult, output, WIDTH, meaning the registered result.
REQ-012 SHALL have ports oZero and oCarry, output, 1 each, meaning the registered flags.

Function
REQ-013 SHALL accept a request on the cycle where iValid && oReady (the "accept" cycle); inputs are sampled only then.
REQ-014 SHALL implement a 3-state FSM: IDLE, BUSY, HOLD; oReady = (IDLE) || (HOLD && iReady).
REQ-015 SHALL complete single-cycle ops ADD, SUB, AND, OR, XOR, NOT(A), SL, SR, CMP as follows: accept at N, HOLD with oValid=1 at N+1.
REQ-016 SHALL, for ADD, keep the result modulo 2^WIDTH, with oCarry = carry-out.
REQ-017 SHALL, for SUB, compute A-B modulo 2^WIDTH, with oCarry = borrow (A<B unsigned).
REQ-018 SHALL, for SL/SR, treat B as a logical shift amount over the full unsigned B; B>=WIDTH yields 0; oCarry=0.
REQ-019 SHALL, for CMP, produce result 1 if A==B, else 0; oCarry=0.
REQ-020 SHALL, for logic ops, drive oCarry=0.
REQ-021 SHALL set oZero = (oAluResult==0) for every op.
REQ-022 SHALL, for an undefined opcode, produce result 0, oZero=1, oCarry=0, with the single-cycle latency.
REQ-023 SHALL hold oValid, oAluResult and the flags stable in HOLD until iReady.
REQ-024 SHALL, on HOLD && iReady && !iValid, go to IDLE and drop oValid next cycle.
REQ-025 SHALL, on HOLD && iReady && iValid, accept the new request; back-to-back single-cycle throughput is 1 result/cycle.
REQ-026 SHALL keep oReady=0 in BUSY; iValid is ignored there.
REQ-027 SHALL hold oValid=0 in IDLE and BUSY; oAluResult keeps its last value.

Reset
REQ-028 SHALL, while iReset=1 at a clock edge, set state=IDLE, oValid=0, oAluResult=0, oZero=0, oCarry=0.
REQ-029 SHALL let reset in BUSY or HOLD abort the operation; the result is discarded and the next accept is one cycle after reset deasserts.
REQ-030 SHALL give reset priority over every handshake event in the same cycle.

Configuration
REQ-031 SHALL provide macro ALU_PIPE_MUL_EN; when defined, opcode MUL is supported.
REQ-032 SHALL implement MUL as an iterative shift-add taking WIDTH cycles in BUSY, then HOLD: accept N, oValid at N+WIDTH+1.
REQ-033 SHALL make the MUL result the low WIDTH bits, with oCarry = 1 if the high WIDTH bits are nonzero.
REQ-034 SHALL, without ALU_PIPE_MUL_EN, treat MUL as undefined (REQ-022), keep BUSY unreachable, and build no multiplier logic.

Structure
REQ-035 SHALL place opcode constants (ADD..MUL), the FSM state typedef and flag bit positions in shared package alu_pkg.
REQ-036 SHALL isolate the multiplier in sub-module alu_mul_iter (start/done handshake, WIDTH param), instantiated only under ALU_PIPE_MUL_EN.

Verification (WIDTH=16)
REQ-037 SHALL cover ADD: A=FFFF, B=0001, iReady=1 -> next cycle oValid=1, result 0000, oZero=1, oCarry=1.
REQ-038 SHALL cover SUB: A=0003, B=0005 -> result FFFE, oCarry=1, oZero=0; SL A=0001, B=0010 -> 0000, oZero=1.
REQ-039 SHALL cover backpressure: CMP A=B=1234 with iReady=0 for 3 cycles -> oValid held with result 0001, oReady=0; iReady=1 with iValid=1 -> same-cycle accept of the next request.
REQ-040 SHALL cover MUL (macro on): A=0100, B=0100 -> oReady=0 for 16 cycles, oValid at accept+17, result 0000, oCarry=1; 0003*0007 -> 0015, oCarry=0.
REQ-041 SHALL cover reset in BUSY: iReset pulsed at MUL cycle 5 -> oValid=0 and outputs 0 next cycle, oReady=1 after deassert, no stale result ever.
REQ-042 SHALL cover the macro off: MUL opcode -> 1-cycle latency, result 0000, oZero=1, oCarry=0.
